// File: rtl/di_host_arbiter_pkg.sv
// Shared types and field widths for the two-master DI host arbiter.
// Holds the arbiter state encoding and the round-robin pick helper.
package di_host_arbiter_pkg;

  localparam int DI_TERM_W   = 16;
  localparam int DI_ADDR_W   = 32;
  localparam int DI_LEN_W    = 32;
  localparam int DI_STATUS_W = 16;
  localparam int DI_WDOG_W   = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT0  = 2'd1,
    ARB_GRANT1  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  // Round-robin choice when the bus is free: on contention the requester that
  // did not own the bus last time wins.
  function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                          input logic last_grant);
    arb_state_e pick;
    pick = ARB_IDLE;
    if (req0 && req1)  pick = last_grant ? ARB_GRANT0 : ARB_GRANT1;
    else if (req0)     pick = ARB_GRANT0;
    else if (req1)     pick = ARB_GRANT1;
    return pick;
  endfunction

endpackage

// File: rtl/di_arb_watchdog.sv
// Grant watchdog for di_host_arbiter; only built when DI_ARB_TIMEOUT_EN is defined.
// Counts granted cycles without DI activity and flags expiry on the last one.
`ifdef DI_ARB_TIMEOUT_EN
module di_arb_watchdog
  import di_host_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic ifclk,
  input  logic resetb,
  input  logic active,
  input  logic kick,
  output logic expire
);

  localparam logic [DI_WDOG_W-1:0] LAST_CNT = DI_WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [DI_WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active || kick) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  // Expiry is combinational so the arbiter releases on the limit cycle itself.
  assign expire = active && !kick && (cnt_q == LAST_CNT);

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/di_host_arbiter.sv
// Round-robin arbiter sharing one DI terminal bus between two host masters.
// Optional grant watchdog enabled by defining DI_ARB_TIMEOUT_EN.
module di_host_arbiter
  import di_host_arbiter_pkg::*;
#(
  parameter int DI_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     ifclk,
  input  logic                     resetb,
  // requester 0
  input  logic [DI_TERM_W-1:0]     h0_term_addr,
  input  logic [DI_ADDR_W-1:0]     h0_reg_addr,
  input  logic [DI_LEN_W-1:0]      h0_len,
  input  logic                     h0_read_mode,
  input  logic                     h0_read_req,
  input  logic                     h0_read,
  input  logic                     h0_write_mode,
  input  logic                     h0_write,
  input  logic [DI_DATA_WIDTH-1:0] h0_reg_datai,
  output logic                     h0_read_rdy,
  output logic                     h0_write_rdy,
  output logic [DI_DATA_WIDTH-1:0] h0_reg_datao,
  output logic [DI_STATUS_W-1:0]   h0_transfer_status,
  output logic                     h0_grant,
  output logic                     h0_timeout,
  // requester 1
  input  logic [DI_TERM_W-1:0]     h1_term_addr,
  input  logic [DI_ADDR_W-1:0]     h1_reg_addr,
  input  logic [DI_LEN_W-1:0]      h1_len,
  input  logic                     h1_read_mode,
  input  logic                     h1_read_req,
  input  logic                     h1_read,
  input  logic                     h1_write_mode,
  input  logic                     h1_write,
  input  logic [DI_DATA_WIDTH-1:0] h1_reg_datai,
  output logic                     h1_read_rdy,
  output logic                     h1_write_rdy,
  output logic [DI_DATA_WIDTH-1:0] h1_reg_datao,
  output logic [DI_STATUS_W-1:0]   h1_transfer_status,
  output logic                     h1_grant,
  output logic                     h1_timeout,
  // DI bus
  output logic [DI_TERM_W-1:0]     di_term_addr,
  output logic [DI_ADDR_W-1:0]     di_reg_addr,
  output logic [DI_LEN_W-1:0]      di_len,
  output logic                     di_read_mode,
  output logic                     di_read_req,
  output logic                     di_read,
  output logic                     di_write_mode,
  output logic                     di_write,
  output logic [DI_DATA_WIDTH-1:0] di_reg_datai,
  input  logic                     di_read_rdy,
  input  logic                     di_write_rdy,
  input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,
  input  logic [DI_STATUS_W-1:0]   di_transfer_status
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       grant0_q, grant0_d;
  logic       grant1_q, grant1_d;
  logic       pend0_q, pend0_d;
  logic       pend1_q, pend1_d;

  logic [1:0] raw_req;
  logic [1:0] eff_req;
  logic       wd_expire;

  assign raw_req = {h1_read_mode | h1_write_mode, h0_read_mode | h0_write_mode};

`ifdef DI_ARB_TIMEOUT_EN
  logic [1:0] block_q, block_d;
  logic [1:0] tmo_q, tmo_d;
  logic [1:0] req_prev_q, req_prev_d;
  logic       wd_kick;

  assign wd_kick = di_read | di_write | di_read_rdy | di_write_rdy;

  di_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .ifclk  (ifclk),
    .resetb (resetb),
    .active (grant0_q | grant1_q),
    .kick   (wd_kick),
    .expire (wd_expire)
  );

  // A timed-out requester is locked out until it drops its request; its flag
  // stays up until the request rises again.
  always_comb begin
    block_d    = block_q;
    tmo_d      = tmo_q;
    req_prev_d = raw_req;
    for (int n = 0; n < 2; n++) begin
      if (raw_req[n] && !req_prev_q[n]) tmo_d[n] = 1'b0;
      if (!raw_req[n])                  block_d[n] = 1'b0;
    end
    if (wd_expire && grant0_q) begin tmo_d[0] = 1'b1; block_d[0] = 1'b1; end
    if (wd_expire && grant1_q) begin tmo_d[1] = 1'b1; block_d[1] = 1'b1; end
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      block_q    <= '0;
      tmo_q      <= '0;
      req_prev_q <= '0;
    end else begin
      block_q    <= block_d;
      tmo_q      <= tmo_d;
      req_prev_q <= req_prev_d;
    end
  end

  assign eff_req    = raw_req & ~block_q;
  assign h0_timeout = tmo_q[0];
  assign h1_timeout = tmo_q[1];
`else
  assign wd_expire  = 1'b0;
  assign eff_req    = raw_req;
  assign h0_timeout = 1'b0;
  assign h1_timeout = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      // RELEASE drives the bus idle for its one cycle but already arbitrates,
      // so a waiting master owns the bus two cycles after the owner dropped.
      ARB_IDLE, ARB_RELEASE: state_d = arb_pick(eff_req[0], eff_req[1], last_grant_q);
      ARB_GRANT0: if (!eff_req[0] || wd_expire) begin
        state_d      = ARB_RELEASE;
        last_grant_d = 1'b0;
      end
      ARB_GRANT1: if (!eff_req[1] || wd_expire) begin
        state_d      = ARB_RELEASE;
        last_grant_d = 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase

    grant0_d = (state_d == ARB_GRANT0);
    grant1_d = (state_d == ARB_GRANT1);

    // A read_req seen while waiting is held for replay on the first granted
    // cycle; dropping the request before the grant discards it.
    pend0_d = 1'b0;
    if (state_q != ARB_GRANT0 && raw_req[0]) pend0_d = pend0_q | h0_read_req;
    pend1_d = 1'b0;
    if (state_q != ARB_GRANT1 && raw_req[1]) pend1_d = pend1_q | h1_read_req;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
    end
  end

  assign h0_grant = grant0_q;
  assign h1_grant = grant1_q;

  always_comb begin
    di_term_addr  = '0;
    di_reg_addr   = '0;
    di_len        = '0;
    di_read_mode  = 1'b0;
    di_read_req   = 1'b0;
    di_read       = 1'b0;
    di_write_mode = 1'b0;
    di_write      = 1'b0;
    di_reg_datai  = '0;
    if (grant0_q) begin
      di_term_addr  = h0_term_addr;
      di_reg_addr   = h0_reg_addr;
      di_len        = h0_len;
      di_read_mode  = h0_read_mode;
      di_read_req   = h0_read_req | pend0_q;
      di_read       = h0_read;
      di_write_mode = h0_write_mode;
      di_write      = h0_write;
      di_reg_datai  = h0_reg_datai;
    end else if (grant1_q) begin
      di_term_addr  = h1_term_addr;
      di_reg_addr   = h1_reg_addr;
      di_len        = h1_len;
      di_read_mode  = h1_read_mode;
      di_read_req   = h1_read_req | pend1_q;
      di_read       = h1_read;
      di_write_mode = h1_write_mode;
      di_write      = h1_write;
      di_reg_datai  = h1_reg_datai;
    end
  end

  // The waiting master stalls because its ready flags stay low.
  assign h0_read_rdy        = grant0_q & di_read_rdy;
  assign h0_write_rdy       = grant0_q & di_write_rdy;
  assign h0_reg_datao       = grant0_q ? di_reg_datao : '0;
  assign h0_transfer_status = grant0_q ? di_transfer_status : '0;
  assign h1_read_rdy        = grant1_q & di_read_rdy;
  assign h1_write_rdy       = grant1_q & di_write_rdy;
  assign h1_reg_datao       = grant1_q ? di_reg_datao : '0;
  assign h1_transfer_status = grant1_q ? di_transfer_status : '0;

endmodule
